usb_tx_sequencer: RTL and testbench
===================================

# usb_tx_sequencer

Controller that sequences the existing `flex_pts_sr` parallel-to-serial shift register to transmit a packet of bytes, LSB first, on the USB TX serial line. It accepts bytes over a valid/ready handshake and generates `load_enable`/`shift_enable` at the configured bit period. It inserts USB bit-stuffing zeros and signals packet completion or underrun. It sits between the TX packet/FIFO logic and the line encoder.

## Interface
- `BIT_PERIOD`, default 8: clock cycles per serial bit; must be ≥ 2.
- `clk`  in  1: system clock; everything is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `tx_data`  in  8: byte to send.
- `tx_valid`  in  1: `tx_data`/`tx_last` are valid.
- `tx_last`  in  1: this byte ends the packet.
- `tx_ready`  out  1: byte accepted when `tx_valid && tx_ready`.
- `serial_out`  out  1: serial bit stream; idles at 1.
- `tx_active`  out  1: packet in progress.
- `tx_done`  out  1: one-cycle pulse after the last bit of a `tx_last` byte.
- `tx_underrun`  out  1: one-cycle pulse when a non-last byte ends with no next byte available.

## Operation
- States: IDLE, SHIFT, STUFF, DONE.
- Reset values (and the state while `rst` is high): IDLE; `tx_ready`=1, `serial_out`=1, `tx_active`=0, `tx_done`=0, `tx_underrun`=0; bit timer, bit count and ones count all 0.
- The shift register's `n_rst` is driven by `~rst`, with `SHIFT_MSB=0` and `NUM_BITS=8`.
- **IDLE**
  - `tx_ready`=1.
  - On `tx_valid`: assert `load_enable` with `parallel_in=tx_data`, latch `tx_last`, clear the timer, bit count and ones count, then go to SHIFT.
- **SHIFT**
  - `serial_out` = shifter output. The timer counts 0..BIT_PERIOD-1.
  - At `timer==BIT_PERIOD-1` (bit end), the timer returns to 0.
  - The ones count increments on a transmitted 1 and clears on a 0.
  - If the count reaches 6 and stuffing is enabled, go to STUFF and do not shift.
  - Otherwise, byte-end handling applies when bit count = 7; else pulse `shift_enable` and increment the bit count.
- **STUFF**
  - Drives `serial_out`=0 for one bit period and clears the ones count.
  - At its bit end, it performs the deferred action (shift, or byte-end handling), then returns to SHIFT.
- **Byte-end handling**
  - `tx_last` latched: go to DONE.
  - Else `tx_ready`=1 for this cycle only. If `tx_valid`, load the new byte, clear the bit count, stay in SHIFT, and keep the ones count (stuffing spans byte boundaries). If not, pulse `tx_underrun` and go to IDLE.
- **DONE**
  - One cycle: `tx_done`=1, `serial_out`=1, then go to IDLE.
- `tx_active`=1 in SHIFT, STUFF and DONE.
- `tx_ready`=0 in SHIFT/STUFF except in the byte-end cycle.
- Inputs are ignored outside the acceptance cycles.

## Timing
- The first bit drives `serial_out` in the cycle after acceptance and is held for BIT_PERIOD cycles.
- An unstuffed byte occupies 8·BIT_PERIOD cycles. Each stuff bit adds BIT_PERIOD cycles.
- Back-to-back bytes have no idle gap: the next byte's bit 0 follows the previous bit 7 directly.
- `tx_done` falls in the cycle after the final bit period. For a single unstuffed byte accepted at cycle 0, that is cycle 8·BIT_PERIOD+1.
- `rst` mid-packet: the next cycle matches the reset values. No `tx_done` or `tx_underrun` pulse is produced.
- Bit-timer width is `$clog2(BIT_PERIOD)`. Bit count is 3 bits. Ones count is 3 bits and saturates at 6.

## Configuration
- `USB_TX_BIT_STUFF_EN`
  - Defined: a zero is inserted after six consecutive transmitted 1s (STUFF state active).
  - Undefined: STUFF is unreachable, the ones counter is removed, and the bit stream is raw data.

## Structure
- Package `usb_tx_pkg`:
  - state enum `tx_seq_state_t` (IDLE, SHIFT, STUFF, DONE);
  - constants `STUFF_THRESHOLD=6` and `BYTE_BITS=8`.
- Single sub-module: `flex_pts_sr` (NUM_BITS=8, SHIFT_MSB=0) as the datapath. All timing and stuffing logic lives in `usb_tx_sequencer`.

## Test plan
All scenarios use BIT_PERIOD=4.

- **Reset:** hold `rst` for 3 cycles → `serial_out`=1, `tx_ready`=1, `tx_active`=0, no pulses.
- **Single byte:** 0xA5 with `tx_last` → `serial_out` is 1,0,1,0,0,1,0,1, each bit held 4 cycles; `tx_done` pulses once 33 cycles after acceptance.
- **Back-to-back with stuffing (macro defined):** 0xFF then 0x00 (last) → 1×6, stuffed 0, 1,1, then 0×8. That is 17 bits (68 cycles). `tx_ready` is high for exactly one cycle at the first byte end.
- **Underrun:** 0x3C not last, `tx_valid` low at the byte end → `tx_underrun` pulses once, no `tx_done`, `serial_out`=1, state returns to IDLE.
- **Reset mid-byte:** assert `rst` 10 cycles into 0x0F → the next cycle shows `serial_out`=1, `tx_active`=0, and `tx_ready`=1 after release.
- **Stuffing compiled out:** 0xFF last → eight 1s, no inserted zero, `tx_done` at cycle 33.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX serial sequencer.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STUFF,
        DONE
    } tx_seq_state_t;

    localparam int unsigned STUFF_THRESHOLD = 6;
    localparam int unsigned BYTE_BITS       = 8;

endpackage

// File: rtl/flex_pts_sr.sv
// Flexible parallel-to-serial shift register; idles and back-fills with 1s.
module flex_pts_sr #(
    parameter int unsigned NUM_BITS  = 4,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                load_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] sr;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sr <= '1;
        end else if (load_enable) begin
            sr <= parallel_in;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                sr <= {sr[NUM_BITS-2:0], 1'b1};
            end else begin
                sr <= {1'b1, sr[NUM_BITS-1:1]};
            end
        end
    end

    assign serial_out = SHIFT_MSB ? sr[NUM_BITS-1] : sr[0];

endmodule

// File: rtl/usb_tx_sequencer.sv
// Sequences flex_pts_sr to send packet bytes LSB first at BIT_PERIOD clocks per bit.
// Define USB_TX_BIT_STUFF_EN to insert a zero after six consecutive transmitted 1s.
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam int unsigned   TW        = $clog2(BIT_PERIOD);
    localparam logic [TW-1:0] TIMER_MAX = TW'(BIT_PERIOD - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(BYTE_BITS - 1);

    tx_seq_state_t state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic          last_q, last_next;
    logic          sr_out, load_enable, shift_enable;
    logic          bit_end, byte_end, do_shift, take, stuff_now;
`ifdef USB_TX_BIT_STUFF_EN
    localparam logic [2:0] STUFF_CNT = 3'(STUFF_THRESHOLD);
    logic [2:0] ones_cnt, ones_next, ones_after;
`endif

    assign bit_end = (timer == TIMER_MAX);

    flex_pts_sr #(
        .NUM_BITS (BYTE_BITS),
        .SHIFT_MSB(1'b0)
    ) u_shifter (
        .clk         (clk),
        .n_rst       (~rst),
        .shift_enable(shift_enable),
        .load_enable (load_enable),
        .parallel_in (tx_data),
        .serial_out  (sr_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            last_q  <= 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
            ones_cnt <= '0;
`endif
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_cnt <= bit_cnt_next;
            last_q  <= last_next;
`ifdef USB_TX_BIT_STUFF_EN
            ones_cnt <= ones_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_cnt_next = bit_cnt;
        last_next    = last_q;
        byte_end     = 1'b0;
        do_shift     = 1'b0;
        stuff_now    = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
        ones_next  = ones_cnt;
        ones_after = sr_out ? ((ones_cnt == STUFF_CNT) ? STUFF_CNT : ones_cnt + 3'd1) : '0;
`endif
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_next   = SHIFT;
                    timer_next   = '0;
                    bit_cnt_next = '0;
`ifdef USB_TX_BIT_STUFF_EN
                    ones_next = '0;
`endif
                end
            end
            SHIFT, STUFF: begin
                timer_next = bit_end ? '0 : timer + TW'(1);
                if (bit_end) begin
`ifdef USB_TX_BIT_STUFF_EN
                    if (state == SHIFT) begin
                        stuff_now = (ones_after == STUFF_CNT);
                        ones_next = stuff_now ? '0 : ones_after;
                    end
`endif
                    // STUFF's bit end replays the shift or byte end it deferred
                    if (stuff_now) begin
                        state_next = STUFF;
                    end else if (bit_cnt == LAST_BIT) begin
                        byte_end = 1'b1;
                    end else begin
                        do_shift   = 1'b1;
                        state_next = SHIFT;
                    end
                end
            end
            DONE: state_next = IDLE;
        endcase

        if (do_shift) begin
            bit_cnt_next = bit_cnt + 3'd1;
        end
        if (byte_end) begin
            if (last_q) begin
                state_next = DONE;
            end else if (tx_valid) begin
                state_next   = SHIFT;
                bit_cnt_next = '0;
            end else begin
                state_next = IDLE;
            end
        end
        take = tx_valid && ((state == IDLE) || (byte_end && !last_q));
        if (take) begin
            last_next = tx_last;
        end
    end

    always_comb begin
        tx_ready     = 1'b1;
        serial_out   = 1'b1;
        tx_active    = 1'b0;
        tx_done      = 1'b0;
        tx_underrun  = 1'b0;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        if (!rst) begin
            load_enable  = take;
            shift_enable = do_shift;
            tx_underrun  = byte_end && !last_q && !tx_valid;
            unique case (state)
                IDLE: tx_ready = 1'b1;
                SHIFT: begin
                    tx_ready   = byte_end && !last_q;
                    serial_out = sr_out;
                    tx_active  = 1'b1;
                end
                STUFF: begin
                    tx_ready   = byte_end && !last_q;
                    serial_out = 1'b0;
                    tx_active  = 1'b1;
                end
                DONE: begin
                    tx_ready  = 1'b0;
                    tx_active = 1'b1;
                    tx_done   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer at BIT_PERIOD=4; expectations follow USB_TX_BIT_STUFF_EN.
module tb_usb_tx_sequencer;

    localparam int unsigned BP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       serial_out;
    logic       tx_active;
    logic       tx_done;
    logic       tx_underrun;

    int vectors     = 0;
    int miscompares = 0;
    logic exp_q[$];
`ifdef USB_TX_BIT_STUFF_EN
    int model_ones = 0;
`endif

    usb_tx_sequencer #(.BIT_PERIOD(BP)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line bits for one byte, LSB first, stuffing carried across bytes.
    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
`ifdef USB_TX_BIT_STUFF_EN
            if (b[i]) model_ones++;
            else model_ones = 0;
            if (model_ones == 6) begin
                exp_q.push_back(1'b0);
                model_ones = 0;
            end
`endif
        end
    endtask

    task automatic offer(input logic [7:0] d, input logic last);
        @(negedge clk);
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL offer_ready: got %b want 1", tx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(output int rdy_seen, output int und_seen, output int cycles);
        logic expb;
        bit   drop;
        rdy_seen = 0;
        und_seen = 0;
        cycles   = 0;
        drop     = 1'b0;
        while (exp_q.size() > 0) begin
            expb = exp_q.pop_front();
            for (int c = 0; c < BP; c++) begin
                @(negedge clk);
                cycles++;
                vectors++;
                if (serial_out !== expb) begin
                    miscompares++;
                    $display("FAIL stream_bit cycle %0d: got %b want %b", cycles, serial_out, expb);
                end
                vectors++;
                if (tx_active !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_active cycle %0d: got %b want 1", cycles, tx_active);
                end
                vectors++;
                if (tx_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_done cycle %0d: got %b want 0", cycles, tx_done);
                end
                if (tx_underrun === 1'b1) und_seen++;
                if (drop) begin
                    tx_valid = 1'b0;
                    drop     = 1'b0;
                end
                if (tx_ready === 1'b1) begin
                    rdy_seen++;
                    drop = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({serial_out, tx_ready, tx_active, tx_done, tx_underrun} !== 5'b11000) begin
                miscompares++;
                $display("FAIL reset_outputs: got %b want 11000",
                         {serial_out, tx_ready, tx_active, tx_done, tx_underrun});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({serial_out, tx_ready, tx_active, tx_done, tx_underrun} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_release: got %b want 11000",
                     {serial_out, tx_ready, tx_active, tx_done, tx_underrun});
        end
    endtask

    task automatic test_single_byte();
        int r, u, cyc;
        push_byte(8'hA5);
        offer(8'hA5, 1'b1);
        tx_valid = 1'b0;
        run_stream(r, u, cyc);
        vectors++;
        if (r != 0 || u != 0) begin
            miscompares++;
            $display("FAIL single_pulses: got ready=%0d underrun=%0d want 0 0", r, u);
        end
        @(negedge clk);
        vectors++;
        if (tx_done !== 1'b1 || serial_out !== 1'b1 || cyc + 1 != 33) begin
            miscompares++;
            $display("FAIL single_done: got done=%b line=%b cycle=%0d want 1 1 33", tx_done, serial_out, cyc + 1);
        end
        @(negedge clk);
        vectors++;
        if (tx_done !== 1'b0 || tx_active !== 1'b0 || tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_idle: got done=%b active=%b ready=%b want 0 0 1", tx_done, tx_active, tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        int r, u, cyc;
        int exp_done;
`ifdef USB_TX_BIT_STUFF_EN
        model_ones = 0;
        exp_done = 69;
`else
        exp_done = 65;
`endif
        push_byte(8'hFF);
        push_byte(8'h00);
        offer(8'hFF, 1'b0);
        tx_data  = 8'h00;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        run_stream(r, u, cyc);
        vectors++;
        if (r != 1 || u != 0) begin
            miscompares++;
            $display("FAIL b2b_pulses: got ready=%0d underrun=%0d want 1 0", r, u);
        end
        @(negedge clk);
        vectors++;
        if (tx_done !== 1'b1 || cyc + 1 != exp_done) begin
            miscompares++;
            $display("FAIL b2b_done: got done=%b cycle=%0d want 1 %0d", tx_done, cyc + 1, exp_done);
        end
        @(negedge clk);
        vectors++;
        if (tx_active !== 1'b0 || tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got active=%b done=%b want 0 0", tx_active, tx_done);
        end
    endtask

    task automatic test_underrun();
        int r, u, cyc, dones;
`ifdef USB_TX_BIT_STUFF_EN
        model_ones = 0;
`endif
        push_byte(8'h3C);
        offer(8'h3C, 1'b0);
        tx_valid = 1'b0;
        run_stream(r, u, cyc);
        vectors++;
        if (r != 1 || u != 1) begin
            miscompares++;
            $display("FAIL underrun_pulses: got ready=%0d underrun=%0d want 1 1", r, u);
        end
        @(negedge clk);
        vectors++;
        if ({serial_out, tx_ready, tx_active, tx_done, tx_underrun} !== 5'b11000) begin
            miscompares++;
            $display("FAIL underrun_idle: got %b want 11000",
                     {serial_out, tx_ready, tx_active, tx_done, tx_underrun});
        end
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (tx_done === 1'b1 || tx_active === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL underrun_quiet: got %0d busy cycles want 0", dones);
        end
    endtask

    task automatic test_reset_mid_byte();
        int busy;
        offer(8'h0F, 1'b1);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (tx_active !== 1'b1 || serial_out !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_before: got active=%b line=%b want 1 1", tx_active, serial_out);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({serial_out, tx_active, tx_done, tx_underrun} !== 4'b1000) begin
            miscompares++;
            $display("FAIL midrst_reset: got %b want 1000", {serial_out, tx_active, tx_done, tx_underrun});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b1 || tx_active !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_release: got ready=%b active=%b want 1 0", tx_ready, tx_active);
        end
        busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_done === 1'b1 || tx_active === 1'b1 || tx_underrun === 1'b1) busy++;
        end
        vectors++;
        if (busy != 0) begin
            miscompares++;
            $display("FAIL midrst_quiet: got %0d busy cycles want 0", busy);
        end
    endtask

    task automatic test_all_ones();
        int r, u, cyc;
        int exp_done;
`ifdef USB_TX_BIT_STUFF_EN
        model_ones = 0;
        exp_done = 37;
`else
        exp_done = 33;
`endif
        push_byte(8'hFF);
        offer(8'hFF, 1'b1);
        tx_valid = 1'b0;
        run_stream(r, u, cyc);
        vectors++;
        if (r != 0 || u != 0) begin
            miscompares++;
            $display("FAIL ones_pulses: got ready=%0d underrun=%0d want 0 0", r, u);
        end
        @(negedge clk);
        vectors++;
        if (tx_done !== 1'b1 || serial_out !== 1'b1 || cyc + 1 != exp_done) begin
            miscompares++;
            $display("FAIL ones_done: got done=%b line=%b cycle=%0d want 1 1 %0d",
                     tx_done, serial_out, cyc + 1, exp_done);
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_reset_mid_byte();
        test_all_ones();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
